// File: rtl/pc_fetch.sv
// Instruction fetch unit: one outstanding imem request, holds each fetched word
// until the decoder accepts it, and follows branch/jump redirects.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [31:0] retired_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic redir_ok;
  logic redir_bad;

  assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      err_q    <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (state_q == HOLD && instr_ready) begin
      cnt_d = cnt_q + 32'd1;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Redirects override the sequential flow; ERR is only left through reset.
    if (state_q != ERR) begin
      if (redir_bad) begin
        err_d    = 1'b1;
        state_d  = ERR;
        pc_d     = pc_q;
        kill_d   = 1'b0;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
      end else if (redir_ok) begin
        pc_d    = redirect_pc;
        state_d = REQ;
        if (state_q == WAIT) begin
          instr_d  = instr_q;
          pc_out_d = pc_out_q;
          kill_d   = !imem_rvalid;
          if (!imem_rvalid) begin
            state_d = WAIT;
          end
        end
      end
    end
  end

  always_comb begin
    imem_req    = !rst && (state_q == REQ) && !redirect_valid;
    instr_valid = !rst && (state_q == HOLD);
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign fetch_err   = err_q;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port imem_req  output  1  one-cycle fetch request strobe.
REQ-005 The block SHALL have port imem_addr  output  32  fetch byte address, always equal to pc.
REQ-006 The block SHALL have port imem_rvalid  input  1  instruction memory response valid.
REQ-007 The block SHALL have port imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-008 The block SHALL have port instr_out  output  32  fetched instruction word for the decoder.
REQ-009 The block SHALL have port instr_valid  output  1  instr_out/pc_out hold a valid instruction.
REQ-010 The block SHALL have port instr_ready  input  1  downstream accepts the instruction.
REQ-011 The block SHALL have port pc_out  output  32  address of instr_out.
REQ-012 The block SHALL have port redirect_valid  input  1  take a branch/jal/jalr target this cycle.
REQ-013 The block SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-014 The block SHALL have port fetch_err  output  1  sticky misaligned-redirect error.
REQ-015 The block SHALL have port retired_cnt  output  32  count of completed instr_valid&instr_ready handshakes.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, ERR.
REQ-017 IDLE: no request; next state REQ.
REQ-018 REQ: imem_req = ~redirect_valid; next state WAIT when imem_req=1, otherwise REQ.
REQ-019 WAIT: await imem_rvalid; at most one request outstanding; the memory returns exactly one response per request, latency >=1 cycle.
REQ-020 WAIT with imem_rvalid=1 and kill=0: instr_out<=imem_rdata, pc_out<=pc, next state HOLD.
REQ-021 WAIT with imem_rvalid=1 and kill=1: response discarded, kill<=0, next state REQ.
REQ-022 HOLD: instr_valid=1; instr_out and pc_out stable until the handshake completes.
REQ-023 HOLD with instr_ready=1 and no redirect: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), retired_cnt+1, next state REQ.
REQ-024 instr_valid SHALL be 1 only in HOLD; the first instruction reaches HOLD at the earliest 3 cycles after reset deassertion with 1-cycle memory latency.
REQ-025 redirect_valid with redirect_pc[1:0]==00, in IDLE/REQ/HOLD: pc<=redirect_pc, next state REQ.
REQ-026 redirect_valid with redirect_pc[1:0]==00, in WAIT: pc<=redirect_pc, kill<=1 unless imem_rvalid=1 this cycle; if imem_rvalid=1 the response is dropped and the next state is REQ.
REQ-027 Redirect and instr_ready both 1 in HOLD: the handshake counts (retired_cnt+1), and redirect_pc takes precedence over pc+4.
REQ-028 redirect_valid with redirect_pc[1:0]!=00 in any state: fetch_err<=1, next state ERR, pc unchanged.
REQ-029 ERR: no requests, instr_valid=0, any response discarded; leaves only on rst.
REQ-030 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 imem_addr SHALL equal pc combinationally in every state.

Reset
REQ-032 rst=1 SHALL set state=IDLE, pc=RESET_PC, kill=0, instr_out=0, pc_out=0, fetch_err=0, retired_cnt=0; imem_req and instr_valid read 0 while rst=1.
REQ-033 rst SHALL take priority over redirect_valid, instr_ready, and imem_rvalid.
REQ-034 The instruction memory SHALL be reset by the same rst; a response pending at reset is not delivered.

Verification
REQ-035 Straight-line run: RESET_PC=0, memory latency 1, instr_ready=1 -> imem_addr 0,4,8,... with one request per instruction; retired_cnt=3 after three handshakes.
REQ-036 Backpressure: instr_ready=0 for 5 cycles in HOLD at pc=8 -> instr_out/pc_out=8 held, no imem_req; instr_ready=1 -> next imem_addr=12.
REQ-037 Redirect in WAIT: pc=0x10 outstanding, redirect_pc=0x100, response arrives 2 cycles later -> that response is never presented; next imem_addr=0x100; pc_out=0x100 on the next instr_valid.
REQ-038 Redirect and instr_ready together in HOLD at pc=0x20 with redirect_pc=0x40 -> retired_cnt+1, next imem_addr=0x40, not 0x24.
REQ-039 Misaligned redirect 0x102 -> fetch_err=1 next cycle, no further imem_req; rst -> fetch_err=0, imem_addr=RESET_PC.
REQ-040 Wrap: redirect to 0xFFFF_FFFC, handshake -> next imem_addr=0x0000_0000.
